temporizador_jogo: RTL and testbench

Timing and input-capture stage directly upstream of the game control unit. Produces the `fimLedsOn`, `fimLedsOff`, `timeout` and `tem_jogada` status signals that the control unit consumes, driven by the state strobes it emits (`estado_ledsOn`, `estado_ledsOff`, `estado_espera`). Also synchronises and edge-detects the player buttons and holds the captured play.

---
 rtl/jogo_pkg.sv | 23 ++
 rtl/detector_jogada.sv | 49 ++++
 rtl/temporizador_jogo.sv | 106 ++++++++++
 tb/tb_temporizador_jogo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the game timing stage.
// Mode encodings and default interval lengths.
package jogo_pkg;

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        CONTA_ON     = 2'd1,
        CONTA_OFF    = 2'd2,
        CONTA_ESPERA = 2'd3
    } modo_t;

    localparam int LEDS_ON_CICLOS  = 500;
    localparam int LEDS_OFF_CICLOS = 250;
    localparam int TIMEOUT_CICLOS  = 5000;
    localparam int N_BOTOES        = 4;

    function automatic int maxDe3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/detector_jogada.sv
// Button synchroniser, press edge detector and play capture.
// A press is a rising edge of the OR of the synchronised buttons.
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES = jogo_pkg::N_BOTOES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada
);

    logic [N_BOTOES-1:0] sync1;
    logic [N_BOTOES-1:0] sync2;
    logic                anterior;
    logic                pressao;

    assign pressao = (|sync2) & ~anterior;

    // Two-flop synchroniser and previous-OR register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            anterior <= 1'b0;
        end else begin
            sync1    <= botoes;
            sync2    <= sync1;
            anterior <= |sync2;
        end
    end

    // Accept a press only while enabled; hold the captured vector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tem_jogada <= 1'b0;
            jogada     <= '0;
        end else begin
            tem_jogada <= pressao & habilita;
            if (pressao && habilita) begin
                jogada <= sync2;
            end
        end
    end

endmodule

// File: rtl/temporizador_jogo.sv
// Interval timer and input capture for the game control unit.
// Mode follows the requested state; count restarts on any change.
module temporizador_jogo
    import jogo_pkg::*;
#(
    parameter int LEDS_ON_CICLOS  = jogo_pkg::LEDS_ON_CICLOS,
    parameter int LEDS_OFF_CICLOS = jogo_pkg::LEDS_OFF_CICLOS,
    parameter int TIMEOUT_CICLOS  = jogo_pkg::TIMEOUT_CICLOS,
    parameter int N_BOTOES        = jogo_pkg::N_BOTOES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                estado_ledsOn,
    input  logic                estado_ledsOff,
    input  logic                estado_espera,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                fimLedsOn,
    output logic                fimLedsOff,
    output logic                timeout,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic [1:0]          db_modo
);

    localparam int MAX_LIM =
        maxDe3(LEDS_ON_CICLOS, LEDS_OFF_CICLOS, TIMEOUT_CICLOS);
    localparam int CW = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

    localparam logic [CW-1:0] FIM_ON  = CW'(LEDS_ON_CICLOS - 1);
    localparam logic [CW-1:0] FIM_OFF = CW'(LEDS_OFF_CICLOS - 1);
    localparam logic [CW-1:0] FIM_ESP = CW'(TIMEOUT_CICLOS - 1);

    modo_t         modo;
    modo_t         modoProx;
    modo_t         mReq;
    logic [CW-1:0] cont;
    logic [CW-1:0] contProx;
    logic [CW-1:0] limAtual;

    // Requested mode, LED-on has highest priority.
    always_comb begin
        mReq = OCIOSO;
        if (estado_ledsOn) begin
            mReq = CONTA_ON;
        end else if (estado_ledsOff) begin
            mReq = CONTA_OFF;
        end else if (estado_espera) begin
            mReq = CONTA_ESPERA;
        end
    end

    // Saturation point of the count for the current mode.
    always_comb begin
        limAtual = '0;
        case (modo)
            CONTA_ON:     limAtual = FIM_ON;
            CONTA_OFF:    limAtual = FIM_OFF;
            CONTA_ESPERA: limAtual = FIM_ESP;
            default:      limAtual = '0;
        endcase
    end

    // Next mode and count: reload on change, else saturating count.
    always_comb begin
        modoProx = modo;
        contProx = cont;
        if (mReq != modo) begin
            modoProx = mReq;
            contProx = '0;
        end else if (modo != OCIOSO && cont != limAtual) begin
            contProx = cont + 1'b1;
        end
    end

    // Mode and count registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            modo <= OCIOSO;
            cont <= '0;
        end else begin
            modo <= modoProx;
            cont <= contProx;
        end
    end

    assign fimLedsOn  = (modo == CONTA_ON) && (mReq == CONTA_ON)
                     && (cont == FIM_ON);
    assign fimLedsOff = (modo == CONTA_OFF) && (mReq == CONTA_OFF)
                     && (cont == FIM_OFF);
    assign timeout    = (modo == CONTA_ESPERA)
                     && (mReq == CONTA_ESPERA)
                     && (cont == FIM_ESP);
    assign db_modo    = modo;

    detector_jogada #(
        .N_BOTOES (N_BOTOES)
    ) uDetector (
        .clock      (clock),
        .reset      (reset),
        .habilita   (estado_espera),
        .botoes     (botoes),
        .tem_jogada (tem_jogada),
        .jogada     (jogada)
    );

endmodule

// File: tb/tb_temporizador_jogo.sv
// Directed bench for temporizador_jogo.
// Inputs change 1 time unit after the rising edge; checks 1 unit later.
module tb_temporizador_jogo;

    logic       clock;
    logic       reset;
    logic       estado_ledsOn;
    logic       estado_ledsOff;
    logic       estado_espera;
    logic [3:0] botoes;
    logic       fimLedsOn;
    logic       fimLedsOff;
    logic       timeout;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic [1:0] db_modo;

    int nPass;
    int nTotal;

    temporizador_jogo #(
        .LEDS_ON_CICLOS  (4),
        .LEDS_OFF_CICLOS (2),
        .TIMEOUT_CICLOS  (10),
        .N_BOTOES        (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .estado_ledsOn  (estado_ledsOn),
        .estado_ledsOff (estado_ledsOff),
        .estado_espera  (estado_espera),
        .botoes         (botoes),
        .fimLedsOn      (fimLedsOn),
        .fimLedsOff     (fimLedsOff),
        .timeout        (timeout),
        .tem_jogada     (tem_jogada),
        .jogada         (jogada),
        .db_modo        (db_modo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        estado_ledsOn = 1'b0;
        estado_ledsOff = 1'b0;
        estado_espera = 1'b0;
        botoes = 4'b0000;
        repeat (3) @(posedge clock);
        #2;
        nTotal++;
        if ({fimLedsOn, fimLedsOff, timeout, tem_jogada} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000",
                     {fimLedsOn, fimLedsOff, timeout, tem_jogada});
        end else nPass++;
        nTotal++;
        if (jogada !== 4'b0000) begin
            $display("FAIL reset_jogada: got %b want 0000", jogada);
        end else nPass++;
        nTotal++;
        if (db_modo !== 2'd0) begin
            $display("FAIL reset_modo: got %0d want 0", db_modo);
        end else nPass++;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_leds_on();
        estado_ledsOn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            nTotal++;
            if (fimLedsOn !== (c >= 5)) begin
                $display("FAIL ledsOn_c%0d: got %b want %b",
                         c, fimLedsOn, (c >= 5));
            end else nPass++;
            nTotal++;
            if (db_modo !== ((c >= 2) ? 2'd1 : 2'd0)) begin
                $display("FAIL ledsOn_modo_c%0d: got %0d want %0d",
                         c, db_modo, (c >= 2) ? 1 : 0);
            end else nPass++;
            nextCycle();
        end
        estado_ledsOn = 1'b0;
        nextCycle();
    endtask

    task automatic test_on_to_off();
        estado_ledsOn = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c < 5) nextCycle();
        end
        #1;
        nTotal++;
        if (fimLedsOn !== 1'b1) begin
            $display("FAIL onOff_fimOn: got %b want 1", fimLedsOn);
        end else nPass++;
        nextCycle();
        estado_ledsOn = 1'b0;
        estado_ledsOff = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            nTotal++;
            if (fimLedsOn !== 1'b0) begin
                $display("FAIL onOff_onLow_c%0d: got %b want 0",
                         c, fimLedsOn);
            end else nPass++;
            nTotal++;
            if (fimLedsOff !== (c >= 3)) begin
                $display("FAIL onOff_fimOff_c%0d: got %b want %b",
                         c, fimLedsOff, (c >= 3));
            end else nPass++;
            nextCycle();
        end
        estado_ledsOff = 1'b0;
        nextCycle();
    endtask

    task automatic test_timeout();
        estado_espera = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            #1;
            nTotal++;
            if (timeout !== (c >= 11)) begin
                $display("FAIL timeout_c%0d: got %b want %b",
                         c, timeout, (c >= 11));
            end else nPass++;
            nextCycle();
        end
        estado_espera = 1'b0;
        #1;
        nTotal++;
        if (timeout !== 1'b0) begin
            $display("FAIL timeout_drop: got %b want 0", timeout);
        end else nPass++;
        nextCycle();
        estado_espera = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            #1;
            nTotal++;
            if (timeout !== (c == 11)) begin
                $display("FAIL timeout_again_c%0d: got %b want %b",
                         c, timeout, (c == 11));
            end else nPass++;
            nextCycle();
        end
        estado_espera = 1'b0;
        nextCycle();
    endtask

    task automatic test_button();
        estado_espera = 1'b1;
        botoes = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) botoes = 4'b0000;
            #1;
            nTotal++;
            if (tem_jogada !== (c == 4)) begin
                $display("FAIL press_pulse_c%0d: got %b want %b",
                         c, tem_jogada, (c == 4));
            end else nPass++;
            nTotal++;
            if (jogada !== ((c >= 4) ? 4'b0100 : 4'b0000)) begin
                $display("FAIL press_jogada_c%0d: got %b want %b",
                         c, jogada, (c >= 4) ? 4'b0100 : 4'b0000);
            end else nPass++;
            nextCycle();
        end
        estado_espera = 1'b0;
        botoes = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) botoes = 4'b0000;
            #1;
            nTotal++;
            if (tem_jogada !== 1'b0 || jogada !== 4'b0100) begin
                $display("FAIL discard_c%0d: got %b/%b want 0/0100",
                         c, tem_jogada, jogada);
            end else nPass++;
            nextCycle();
        end
    endtask

    task automatic test_timeout_press();
        estado_espera = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 8) botoes = 4'b0010;
            #1;
            nTotal++;
            if (timeout !== (c >= 11) || tem_jogada !== (c == 11)) begin
                $display("FAIL both_c%0d: got to=%b tj=%b want to=%b tj=%b",
                         c, timeout, tem_jogada, (c >= 11), (c == 11));
            end else nPass++;
            nextCycle();
        end
        nTotal++;
        if (jogada !== 4'b0010) begin
            $display("FAIL both_jogada: got %b want 0010", jogada);
        end else nPass++;
        estado_espera = 1'b0;
        botoes = 4'b0000;
        repeat (4) nextCycle();
    endtask

    task automatic test_reset_mid();
        estado_espera = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c < 8) nextCycle();
        end
        #2;
        reset = 1'b1;
        #1;
        nTotal++;
        if ({fimLedsOn, fimLedsOff, timeout, tem_jogada} !== 4'b0000
            || jogada !== 4'b0000) begin
            $display("FAIL midReset_out: got %b %b want 0000 0000",
                     {fimLedsOn, fimLedsOff, timeout, tem_jogada}, jogada);
        end else nPass++;
        nTotal++;
        if (db_modo !== 2'd0) begin
            $display("FAIL midReset_modo: got %0d want 0", db_modo);
        end else nPass++;
        nextCycle();
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            nTotal++;
            if (timeout !== (c >= 11)) begin
                $display("FAIL postReset_c%0d: got %b want %b",
                         c, timeout, (c >= 11));
            end else nPass++;
            nextCycle();
        end
        estado_espera = 1'b0;
        nextCycle();
    endtask

    initial begin
        nPass = 0;
        nTotal = 0;
        test_reset();
        test_leds_on();
        test_on_to_off();
        test_timeout();
        test_button();
        test_timeout_press();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
